// File: rtl/intadd_drv_if.sv
// Bus bundle for intadd_drv: operand stream in, add-cell port, result stream out.
// master = the sequencer, slave = the surrounding environment.
interface intadd_drv_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_src0;
    logic [127:0] in_src1;
    logic [127:0] add_src0;
    logic [127:0] add_src1;
    logic         add_sign_s0;
    logic         add_sign_s1;
    logic         add_sign_d;
    logic [127:0] add_dst;
    logic [127:0] add_st;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_dst;
    logic [11:0]  out_st;
    logic         out_last;

    modport master (
        input  in_valid, in_src0, in_src1,
        input  add_dst, add_st,
        input  out_ready,
        output in_ready,
        output add_src0, add_src1,
        output add_sign_s0, add_sign_s1, add_sign_d,
        output out_valid, out_dst, out_st, out_last
    );

    modport slave (
        output in_valid, in_src0, in_src1,
        output add_dst, add_st,
        output out_ready,
        input  in_ready,
        input  add_src0, add_src1,
        input  add_sign_s0, add_sign_s1, add_sign_d,
        input  out_valid, out_dst, out_st, out_last
    );
endinterface

// File: rtl/intadd_drv.sv
// Sequencing front-end for the 4-lane 32-bit add cell: operand staging,
// result FIFO with last marker, and per-job lt/eq/gt lane counters.
module intadd_drv #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_job_start,
    input  logic [CNT_W-1:0] i_job_len,
    input  logic             i_cfg_sign_s0,
    input  logic             i_cfg_sign_s1,
    input  logic             i_cfg_sign_d,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W+1:0] o_lt_cnt,
    output logic [CNT_W+1:0] o_eq_cnt,
    output logic [CNT_W+1:0] o_gt_cnt,
    intadd_drv_if.master     bus
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_issued;
    logic             r_sign_s0;
    logic             r_sign_s1;
    logic             r_sign_d;
    logic [127:0]     r_src0;
    logic [127:0]     r_src1;
    logic             r_stg_valid;
    logic             r_stg_last;
    logic [127:0]     r_mem_dst [DEPTH];
    logic [11:0]      r_mem_st [DEPTH];
    logic             r_mem_last [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [CNT_W+1:0] r_lt;
    logic [CNT_W+1:0] r_eq;
    logic [CNT_W+1:0] r_gt;

    logic             w_start;
    logic             w_in_ready;
    logic             w_fire;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_is_last;
    logic [AW:0]      w_occ;
    logic [11:0]      w_st_pk;
    logic [2:0]       w_lt_pc;
    logic [2:0]       w_eq_pc;
    logic [2:0]       w_gt_pc;
    logic             w_unused_st;

    assign w_start    = i_job_start && (r_state == S_IDLE);
    assign w_empty    = (r_count == '0);
    // Staged beat counts as occupied so the FIFO can never overflow.
    assign w_occ      = r_count + {{AW{1'b0}}, r_stg_valid};
    assign w_in_ready = (r_state == S_RUN) && (r_issued < r_len)
                        && (w_occ < (AW+1)'(DEPTH));
    assign w_fire     = bus.in_valid && w_in_ready;
    assign w_push     = r_stg_valid;
    assign w_pop      = !w_empty && bus.out_ready;
    assign w_is_last  = (r_issued == r_len - CNT_W'(1));
    assign w_unused_st = ^bus.add_st;

    // Repack cell status to {gt,eq,lt} per lane and count set flags.
    always_comb begin
        w_st_pk = '0;
        w_lt_pc = '0;
        w_eq_pc = '0;
        w_gt_pc = '0;
        for (int i = 0; i < 4; i++) begin
            w_st_pk[3*i +: 3] = {bus.add_st[32*i+2],
                                 bus.add_st[32*i+1],
                                 bus.add_st[32*i]};
            w_lt_pc = w_lt_pc + {2'b00, bus.add_st[32*i]};
            w_eq_pc = w_eq_pc + {2'b00, bus.add_st[32*i+1]};
            w_gt_pc = w_gt_pc + {2'b00, bus.add_st[32*i+2]};
        end
    end

    // Job sequencing FSM next-state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_job_start)
                    w_next = (i_job_len == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_fire && w_is_last)
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_empty && !r_stg_valid)
                    w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM state, latched job config and issued-beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_issued  <= '0;
            r_sign_s0 <= 1'b0;
            r_sign_s1 <= 1'b0;
            r_sign_d  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_len     <= i_job_len;
                r_issued  <= '0;
                r_sign_s0 <= i_cfg_sign_s0;
                r_sign_s1 <= i_cfg_sign_s1;
                r_sign_d  <= i_cfg_sign_d;
            end else if (w_fire) begin
                r_issued <= r_issued + CNT_W'(1);
            end
        end
    end

    // Stage register feeding the cell; operands hold when no beat fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src0      <= '0;
            r_src1      <= '0;
            r_stg_valid <= 1'b0;
            r_stg_last  <= 1'b0;
        end else begin
            r_stg_valid <= w_fire;
            if (w_fire) begin
                r_src0     <= bus.in_src0;
                r_src1     <= bus.in_src1;
                r_stg_last <= w_is_last;
            end
        end
    end

    // Result FIFO storage; capture cell output while the stage is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dst[r_wr_ptr]  <= bus.add_dst;
            r_mem_st[r_wr_ptr]   <= w_st_pk;
            r_mem_last[r_wr_ptr] <= r_stg_last;
        end
    end

    // Result FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Per-job lane counters; cleared by an accepted start, held after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lt <= '0;
            r_eq <= '0;
            r_gt <= '0;
        end else if (w_start) begin
            r_lt <= '0;
            r_eq <= '0;
            r_gt <= '0;
        end else if (w_push) begin
            r_lt <= r_lt + (CNT_W+2)'(w_lt_pc);
            r_eq <= r_eq + (CNT_W+2)'(w_eq_pc);
            r_gt <= r_gt + (CNT_W+2)'(w_gt_pc);
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.add_src0    = r_src0;
    assign bus.add_src1    = r_src1;
    assign bus.add_sign_s0 = r_sign_s0;
    assign bus.add_sign_s1 = r_sign_s1;
    assign bus.add_sign_d  = r_sign_d;
    assign bus.out_valid   = !w_empty;
    assign bus.out_dst     = r_mem_dst[r_rd_ptr];
    assign bus.out_st      = r_mem_st[r_rd_ptr];
    assign bus.out_last    = r_mem_last[r_rd_ptr] && !w_empty;

    assign o_busy   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done   = (r_state == S_DONE);
    assign o_lt_cnt = r_lt;
    assign o_eq_cnt = r_eq;
    assign o_gt_cnt = r_gt;

endmodule

// File: tb/tb_intadd_drv.sv
// Testbench for intadd_drv: behavioural add cell, randomized streams,
// per-beat reference model and count checks.
module tb_intadd_drv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_start = 1'b0;
    logic [15:0] job_len = '0;
    logic        cs0 = 1'b0;
    logic        cs1 = 1'b0;
    logic        csd = 1'b0;
    logic        busy;
    logic        done;
    logic [17:0] lt_cnt;
    logic [17:0] eq_cnt;
    logic [17:0] gt_cnt;

    intadd_drv_if bus ();

    intadd_drv #(.DEPTH(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_job_start  (job_start),
        .i_job_len    (job_len),
        .i_cfg_sign_s0(cs0),
        .i_cfg_sign_s1(cs1),
        .i_cfg_sign_d (csd),
        .o_busy       (busy),
        .o_done       (done),
        .o_lt_cnt     (lt_cnt),
        .o_eq_cnt     (eq_cnt),
        .o_gt_cnt     (gt_cnt),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    // Behavioural add cell: lane sums and lt/eq/gt flags.
    always_comb begin
        bus.add_dst = '0;
        bus.add_st  = '0;
        for (int i = 0; i < 4; i++) begin
            bus.add_dst[32*i +: 32] = bus.add_src0[32*i +: 32] + bus.add_src1[32*i +: 32];
            if (bus.add_sign_s0 && bus.add_sign_s1) begin
                bus.add_st[32*i]   = $signed(bus.add_src0[32*i +: 32]) < $signed(bus.add_src1[32*i +: 32]);
                bus.add_st[32*i+2] = $signed(bus.add_src0[32*i +: 32]) > $signed(bus.add_src1[32*i +: 32]);
            end else begin
                bus.add_st[32*i]   = bus.add_src0[32*i +: 32] < bus.add_src1[32*i +: 32];
                bus.add_st[32*i+2] = bus.add_src0[32*i +: 32] > bus.add_src1[32*i +: 32];
            end
            bus.add_st[32*i+1] = bus.add_src0[32*i +: 32] == bus.add_src1[32*i +: 32];
        end
    end

    int checks = 0;
    int errors = 0;

    logic [127:0] g_a[$];
    logic [127:0] g_b[$];
    logic [127:0] o_dst_q[$];
    logic [11:0]  o_st_q[$];
    logic         o_last_q[$];

    int r_fires, r_done_cnt, r_done_cyc, r_ready_cyc, r_timeout;
    int r_sign_bad, r_fires_at_hold, r_first_fire, r_first_out, r_last_pop;
    logic [127:0] r_src_at1;

    function automatic logic [127:0] model_dst(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] d;
        longint s;
        d = '0;
        for (int l = 0; l < 4; l++) begin
            s = longint'({32'd0, a[32*l +: 32]}) + longint'({32'd0, b[32*l +: 32]});
            d[32*l +: 32] = s[31:0];
        end
        return d;
    endfunction

    function automatic logic [11:0] model_st(input logic [127:0] a, input logic [127:0] b, input bit sgn);
        logic [11:0] st;
        longint x, y;
        st = '0;
        for (int l = 0; l < 4; l++) begin
            if (sgn) begin
                x = longint'($signed(a[32*l +: 32]));
                y = longint'($signed(b[32*l +: 32]));
            end else begin
                x = longint'({32'd0, a[32*l +: 32]});
                y = longint'({32'd0, b[32*l +: 32]});
            end
            st[3*l +: 3] = (x < y) ? 3'b001 : ((x == y) ? 3'b010 : 3'b100);
        end
        return st;
    endfunction

    // which: 0 = lt, 1 = eq, 2 = gt
    function automatic int exp_cnt(input int len, input bit sgn, input int which);
        int n;
        logic [11:0] st;
        n = 0;
        for (int i = 0; i < len; i++) begin
            st = model_st(g_a[i], g_b[i], sgn);
            for (int l = 0; l < 4; l++)
                n += int'(st[3*l + which]);
        end
        return n;
    endfunction

    task automatic gen_ops(input int n);
        logic [127:0] a, b;
        g_a.delete();
        g_b.delete();
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < 4; l++) begin
                a[32*l +: 32] = $urandom;
                b[32*l +: 32] = ($urandom_range(3) == 0) ? a[32*l +: 32] : $urandom;
            end
            g_a.push_back(a);
            g_b.push_back(b);
        end
    endtask

    // Runs one job; records handshake events and result beats, no checking.
    task automatic run_job(input int len, input bit s0, input bit s1, input bit sd,
                           input int vp, input int rp, input int hold,
                           input int budget, input int restart_at);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        o_dst_q.delete();
        o_st_q.delete();
        o_last_q.delete();
        r_fires = 0; r_done_cnt = 0; r_done_cyc = -1; r_ready_cyc = 0;
        r_timeout = 0; r_sign_bad = 0; r_fires_at_hold = 0;
        r_first_fire = -1; r_first_out = -1; r_last_pop = -1;
        r_src_at1 = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        job_start = 1'b1;
        job_len = 16'(len);
        cs0 = s0; cs1 = s1; csd = sd;
        @(posedge clk);
        #1;
        forever begin
            job_start = (cyc == restart_at);
            if (cyc == restart_at) job_len = 16'd2;
            bus.in_valid = (idx < len) && ($urandom_range(99) < vp);
            bus.in_src0 = (idx < len) ? g_a[idx] : '0;
            bus.in_src1 = (idx < len) ? g_b[idx] : '0;
            bus.out_ready = (cyc >= hold) && ($urandom_range(99) < rp);
            @(negedge clk);
            if (bus.in_ready) r_ready_cyc++;
            if ({bus.add_sign_s0, bus.add_sign_s1, bus.add_sign_d} !== {s0, s1, sd})
                r_sign_bad = 1;
            if (r_first_fire >= 0 && cyc == r_first_fire + 1)
                r_src_at1 = bus.add_src0;
            if (bus.in_valid && bus.in_ready) begin
                if (r_first_fire < 0) r_first_fire = cyc;
                idx++;
                r_fires++;
            end
            if (bus.out_valid && r_first_out < 0) r_first_out = cyc;
            if (bus.out_valid && bus.out_ready) begin
                o_dst_q.push_back(bus.out_dst);
                o_st_q.push_back(bus.out_st);
                o_last_q.push_back(bus.out_last);
                r_last_pop = cyc;
            end
            if (done) begin
                r_done_cnt++;
                if (r_done_cyc < 0) r_done_cyc = cyc;
            end
            if (cyc == hold - 1) r_fires_at_hold = r_fires;
            cyc++;
            if (r_done_cnt > 0 && !done) break;
            if (cyc >= budget) begin
                r_timeout = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        job_start = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_src0 = '0;
        bus.in_src1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, bus.in_ready, bus.out_valid, bus.out_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 00000", {busy, done, bus.in_ready, bus.out_valid, bus.out_last});
        end
        checks++;
        if ((bus.add_src0 | bus.add_src1) !== '0) begin
            errors++;
            $display("FAIL reset_src got %h/%h want 0", bus.add_src0, bus.add_src1);
        end
        checks++;
        if ({bus.add_sign_s0, bus.add_sign_s1, bus.add_sign_d} !== 3'b0) begin
            errors++;
            $display("FAIL reset_sign got %b want 000", {bus.add_sign_s0, bus.add_sign_s1, bus.add_sign_d});
        end
        checks++;
        if ({lt_cnt, eq_cnt, gt_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d/%0d want 0/0/0", lt_cnt, eq_cnt, gt_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        logic [127:0] a, b;
        a = '0; b = '0;
        a[31:0] = 32'd5;
        b[31:0] = 32'd3;
        g_a.delete(); g_b.delete();
        g_a.push_back(a); g_b.push_back(b);
        run_job(1, 0, 0, 0, 100, 100, 0, 50, -1);
        checks++;
        if (r_timeout != 0 || o_dst_q.size() != 1) begin
            errors++;
            $display("FAIL single_beats got %0d beats timeout=%0d want 1 beat", o_dst_q.size(), r_timeout);
        end else begin
            checks++;
            if (o_dst_q[0] !== model_dst(a, b) || o_dst_q[0][31:0] !== 32'd8) begin
                errors++;
                $display("FAIL single_dst got %h want %h", o_dst_q[0], model_dst(a, b));
            end
            checks++;
            if (o_st_q[0] !== 12'b010_010_010_100 || o_last_q[0] !== 1'b1) begin
                errors++;
                $display("FAIL single_st got %b last %b want 010010010100 last 1", o_st_q[0], o_last_q[0]);
            end
        end
        checks++;
        if (r_src_at1[31:0] !== 32'd5) begin
            errors++;
            $display("FAIL single_src_t1 got %h want 5", r_src_at1[31:0]);
        end
        checks++;
        if (r_first_out - r_first_fire != 2) begin
            errors++;
            $display("FAIL single_latency got %0d want 2", r_first_out - r_first_fire);
        end
        checks++;
        if (gt_cnt !== 18'd1 || eq_cnt !== 18'd3 || lt_cnt !== 18'd0) begin
            errors++;
            $display("FAIL single_cnt got lt%0d eq%0d gt%0d want lt0 eq3 gt1", lt_cnt, eq_cnt, gt_cnt);
        end
        checks++;
        if (r_done_cnt != 1 || r_done_cyc - r_last_pop < 1 || r_done_cyc - r_last_pop > 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done got cnt %0d gap %0d busy %b want cnt 1 gap 1..2 busy 0",
                     r_done_cnt, r_done_cyc - r_last_pop, busy);
        end
    endtask

    task automatic test_signed();
        logic [127:0] a, b;
        a = '0; b = '0;
        a[31:0] = 32'hFFFF_FFFF;
        b[31:0] = 32'd1;
        g_a.delete(); g_b.delete();
        g_a.push_back(a); g_b.push_back(b);
        run_job(1, 1, 1, 1, 100, 100, 0, 50, -1);
        checks++;
        if (r_sign_bad != 0 || {bus.add_sign_s0, bus.add_sign_s1, bus.add_sign_d} !== 3'b111) begin
            errors++;
            $display("FAIL signed_cfg got bad=%0d now %b want 0/111", r_sign_bad,
                     {bus.add_sign_s0, bus.add_sign_s1, bus.add_sign_d});
        end
        checks++;
        if (o_st_q.size() != 1 || o_st_q[0][2:0] !== 3'b001 || o_dst_q[0] !== model_dst(a, b)) begin
            errors++;
            $display("FAIL signed_st got %0d beats want lane0 001 sum %h", o_st_q.size(), model_dst(a, b));
        end
        checks++;
        if (lt_cnt !== 18'd1 || eq_cnt !== 18'd3 || gt_cnt !== 18'd0) begin
            errors++;
            $display("FAIL signed_cnt got lt%0d eq%0d gt%0d want lt1 eq3 gt0", lt_cnt, eq_cnt, gt_cnt);
        end
    endtask

    task automatic test_backpressure();
        gen_ops(8);
        run_job(8, 0, 0, 0, 100, 100, 20, 200, -1);
        checks++;
        if (r_fires_at_hold != 4) begin
            errors++;
            $display("FAIL bp_stall got %0d fires want 4", r_fires_at_hold);
        end
        checks++;
        if (r_timeout != 0 || o_dst_q.size() != 8 || r_done_cnt != 1) begin
            errors++;
            $display("FAIL bp_count got %0d beats done %0d timeout %0d want 8/1/0",
                     o_dst_q.size(), r_done_cnt, r_timeout);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= o_dst_q.size()) begin
                errors++;
                $display("FAIL bp_beat%0d got missing want present", i);
            end else if (o_dst_q[i] !== model_dst(g_a[i], g_b[i]) ||
                         o_st_q[i] !== model_st(g_a[i], g_b[i], 0) ||
                         o_last_q[i] !== (i == 7)) begin
                errors++;
                $display("FAIL bp_beat%0d got %h %b %b want %h %b %b", i, o_dst_q[i], o_st_q[i], o_last_q[i],
                         model_dst(g_a[i], g_b[i]), model_st(g_a[i], g_b[i], 0), (i == 7));
            end
        end
        checks++;
        if (lt_cnt !== 18'(exp_cnt(8, 0, 0)) || eq_cnt !== 18'(exp_cnt(8, 0, 1)) ||
            gt_cnt !== 18'(exp_cnt(8, 0, 2))) begin
            errors++;
            $display("FAIL bp_cnt got %0d/%0d/%0d want %0d/%0d/%0d", lt_cnt, eq_cnt, gt_cnt,
                     exp_cnt(8, 0, 0), exp_cnt(8, 0, 1), exp_cnt(8, 0, 2));
        end
    endtask

    task automatic test_zero_len();
        run_job(0, 0, 0, 0, 100, 100, 0, 20, -1);
        checks++;
        if (r_done_cnt != 1 || r_done_cyc < 0 || r_done_cyc > 1) begin
            errors++;
            $display("FAIL zero_done got cnt %0d at %0d want cnt 1 at 0..1", r_done_cnt, r_done_cyc);
        end
        checks++;
        if (r_ready_cyc != 0 || o_dst_q.size() != 0) begin
            errors++;
            $display("FAIL zero_ready got %0d ready %0d beats want 0/0", r_ready_cyc, o_dst_q.size());
        end
        checks++;
        if ({lt_cnt, eq_cnt, gt_cnt} !== '0) begin
            errors++;
            $display("FAIL zero_cnt got %0d/%0d/%0d want 0/0/0", lt_cnt, eq_cnt, gt_cnt);
        end
    endtask

    task automatic test_restart();
        gen_ops(6);
        run_job(6, 0, 0, 0, 100, 100, 0, 100, 3);
        checks++;
        if (r_timeout != 0 || o_dst_q.size() != 6 || r_done_cnt != 1) begin
            errors++;
            $display("FAIL restart_len got %0d beats done %0d want 6/1", o_dst_q.size(), r_done_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= o_last_q.size()) begin
                errors++;
                $display("FAIL restart_beat%0d got missing want present", i);
            end else if (o_last_q[i] !== (i == 5) || o_dst_q[i] !== model_dst(g_a[i], g_b[i])) begin
                errors++;
                $display("FAIL restart_beat%0d got %h last %b want %h last %b", i, o_dst_q[i],
                         o_last_q[i], model_dst(g_a[i], g_b[i]), (i == 5));
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle got busy %b want 0", busy);
        end
    endtask

    task automatic test_reset_midjob();
        int idx;
        int cyc;
        int dseen;
        gen_ops(6);
        idx = 0; cyc = 0; dseen = 0;
        job_start = 1'b1;
        job_len = 16'd6;
        cs0 = 1'b0; cs1 = 1'b0; csd = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        job_start = 1'b0;
        bus.in_valid = 1'b1;
        while (idx < 2 && cyc < 20) begin
            bus.in_src0 = g_a[idx];
            bus.in_src1 = g_b[idx];
            @(negedge clk);
            if (bus.in_ready) idx++;
            cyc++;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        bus.in_src0 = g_a[2];
        bus.in_src1 = g_b[2];
        @(negedge clk);
        checks++;
        if (idx != 2 || busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got idx %0d busy %b ready %b want 2/1/1", idx, busy, bus.in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, bus.out_valid, bus.in_ready} !== 4'b0 || {lt_cnt, eq_cnt, gt_cnt} !== '0) begin
            errors++;
            $display("FAIL midrst_state got %b cnt %0d/%0d/%0d want 0000 0/0/0",
                     {busy, done, bus.out_valid, bus.in_ready}, lt_cnt, eq_cnt, gt_cnt);
        end
        repeat (5) begin
            @(negedge clk);
            if (done) dseen++;
        end
        checks++;
        if (dseen != 0) begin
            errors++;
            $display("FAIL midrst_done got %0d done cycles want 0", dseen);
        end
    endtask

    task automatic test_random_stream();
        int bad;
        bit sgn;
        sgn = 1'($urandom_range(1));
        gen_ops(100);
        run_job(100, sgn, sgn, 0, 60, 60, 0, 3000, -1);
        checks++;
        if (r_timeout != 0 || o_dst_q.size() != 100 || r_done_cnt != 1) begin
            errors++;
            $display("FAIL rand_count got %0d beats done %0d timeout %0d want 100/1/0",
                     o_dst_q.size(), r_done_cnt, r_timeout);
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (i >= o_dst_q.size()) begin
                errors++;
                if (bad++ < 5) $display("FAIL rand_beat%0d got missing want present", i);
            end else if (o_dst_q[i] !== model_dst(g_a[i], g_b[i]) ||
                         o_st_q[i] !== model_st(g_a[i], g_b[i], sgn) ||
                         o_last_q[i] !== (i == 99)) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL rand_beat%0d got %h %b %b want %h %b %b", i, o_dst_q[i], o_st_q[i],
                             o_last_q[i], model_dst(g_a[i], g_b[i]), model_st(g_a[i], g_b[i], sgn), (i == 99));
            end
        end
        checks++;
        if (lt_cnt !== 18'(exp_cnt(100, sgn, 0)) || eq_cnt !== 18'(exp_cnt(100, sgn, 1)) ||
            gt_cnt !== 18'(exp_cnt(100, sgn, 2))) begin
            errors++;
            $display("FAIL rand_cnt got %0d/%0d/%0d want %0d/%0d/%0d", lt_cnt, eq_cnt, gt_cnt,
                     exp_cnt(100, sgn, 0), exp_cnt(100, sgn, 1), exp_cnt(100, sgn, 2));
        end
        checks++;
        if (32'(lt_cnt) + 32'(eq_cnt) + 32'(gt_cnt) != 32'd400) begin
            errors++;
            $display("FAIL rand_sum got %0d want 400", 32'(lt_cnt) + 32'(eq_cnt) + 32'(gt_cnt));
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_signed();
        test_backpressure();
        test_zero_len();
        test_restart();
        test_reset_midjob();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
